// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the ID/EX stage.
// The master side drives ID fields and forwarding sources; the slave is the stage.
interface id_ex_stage_if #(
    parameter int W  = 32,
    parameter int RW = 5
);
    logic          stall;
    logic          flush;
    logic          id_valid;
    logic [W-1:0]  id_pc;
    logic [W-1:0]  id_rs_data;
    logic [W-1:0]  id_rt_data;
    logic [W-1:0]  id_imm32;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [4:0]    id_shamt;
    logic [4:0]    id_aluctrl;
    logic          id_alusrc;
    logic          id_regdst;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_memwrite;
    logic          id_memtoreg;
    logic          exmem_regwrite;
    logic [RW-1:0] exmem_rd;
    logic [W-1:0]  exmem_result;
    logic          memwb_regwrite;
    logic [RW-1:0] memwb_rd;
    logic [W-1:0]  memwb_result;
    logic          load_use;
    logic          ex_valid;
    logic [W-1:0]  ex_pc;
    logic [W-1:0]  ex_data1;
    logic [W-1:0]  ex_data2;
    logic [W-1:0]  ex_store_data;
    logic [4:0]    ex_aluctrl;
    logic [4:0]    ex_shamt;
    logic [RW-1:0] ex_wreg;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_memtoreg;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm32,
               id_rs, id_rt, id_rd, id_shamt, id_aluctrl, id_alusrc, id_regdst,
               id_regwrite, id_memread, id_memwrite, id_memtoreg,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  load_use, ex_valid, ex_pc, ex_data1, ex_data2, ex_store_data,
               ex_aluctrl, ex_shamt, ex_wreg, ex_regwrite, ex_memread,
               ex_memwrite, ex_memtoreg
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm32,
               id_rs, id_rt, id_rd, id_shamt, id_aluctrl, id_alusrc, id_regdst,
               id_regwrite, id_memread, id_memwrite, id_memtoreg,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output load_use, ex_valid, ex_pc, ex_data1, ex_data2, ex_store_data,
               ex_aluctrl, ex_shamt, ex_wreg, ex_regwrite, ex_memread,
               ex_memwrite, ex_memtoreg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use bubble insertion, feeding the ALU directly.
module id_ex_stage #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic          valid;
        logic [W-1:0]  pc;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wreg;
        logic [W-1:0]  rs_data;
        logic [W-1:0]  rt_data;
        logic [W-1:0]  imm;
        logic          alusrc;
        logic [4:0]    aluctrl;
        logic [4:0]    shamt;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
    } ex_state_t;

    ex_state_t state_q;
    ex_state_t state_d;
    logic      load_use;

    // rt is compared even for I-type; a false hazard only costs one bubble.
    always_comb begin
        load_use = state_q.valid && state_q.memread && (state_q.wreg != '0) &&
                   bus.id_valid &&
                   ((state_q.wreg == bus.id_rs) || (state_q.wreg == bus.id_rt));
    end

    always_comb begin
        state_d = state_q;
        if (bus.stall) begin
            state_d = state_q;
        end else if (bus.flush || load_use) begin
            state_d = '0;
        end else begin
            state_d.valid    = bus.id_valid;
            state_d.pc       = bus.id_pc;
            state_d.rs       = bus.id_rs;
            state_d.rt       = bus.id_rt;
            state_d.wreg     = bus.id_regdst ? bus.id_rd : bus.id_rt;
            state_d.rs_data  = bus.id_rs_data;
            state_d.rt_data  = bus.id_rt_data;
            state_d.imm      = bus.id_imm32;
            state_d.alusrc   = bus.id_alusrc;
            state_d.aluctrl  = bus.id_aluctrl;
            state_d.shamt    = bus.id_shamt;
            state_d.regwrite = bus.id_valid & bus.id_regwrite;
            state_d.memread  = bus.id_valid & bus.id_memread;
            state_d.memwrite = bus.id_valid & bus.id_memwrite;
            state_d.memtoreg = bus.id_valid & bus.id_memtoreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand 0 is rs, operand 1 is rt; the younger EX/MEM result wins.
    logic [RW-1:0] src_idx [2];
    logic [W-1:0]  src_raw [2];
    logic [W-1:0]  src_fwd [2];

    assign src_idx[0] = state_q.rs;
    assign src_idx[1] = state_q.rt;
    assign src_raw[0] = state_q.rs_data;
    assign src_raw[1] = state_q.rt_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign src_fwd[gi] =
                (src_idx[gi] == '0) ? src_raw[gi] :
                (bus.exmem_regwrite && (bus.exmem_rd == src_idx[gi])) ? bus.exmem_result :
                (bus.memwb_regwrite && (bus.memwb_rd == src_idx[gi])) ? bus.memwb_result :
                src_raw[gi];
        end
    endgenerate

    assign bus.load_use      = load_use;
    assign bus.ex_valid      = state_q.valid;
    assign bus.ex_pc         = state_q.pc;
    assign bus.ex_data1      = src_fwd[0];
    assign bus.ex_data2      = state_q.alusrc ? state_q.imm : src_fwd[1];
    assign bus.ex_store_data = src_fwd[1];
    assign bus.ex_aluctrl    = state_q.aluctrl;
    assign bus.ex_shamt      = state_q.shamt;
    assign bus.ex_wreg       = state_q.wreg;
    assign bus.ex_regwrite   = state_q.regwrite;
    assign bus.ex_memread    = state_q.memread;
    assign bus.ex_memwrite   = state_q.memwrite;
    assign bus.ex_memtoreg   = state_q.memtoreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus a randomized run against a behavioural model of the
// ID/EX stage (update priority, forwarding priority, load-use detection).
module tb_id_ex_stage;
    localparam int W  = 32;
    localparam int RW = 5;
    localparam logic [4:0] ALU_ADDU = 5'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.W(W), .RW(RW)) bus();
    id_ex_stage #(.W(W), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Expected contents of the EX slot
    typedef struct {
        bit          valid;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, wreg, aluctrl, shamt;
        bit          alusrc, rw, mr, mw, mtr;
    } slot_t;
    slot_t m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0; bus.id_pc = '0;
        bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm32 = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_shamt = '0;
        bus.id_aluctrl = '0; bus.id_alusrc = 0; bus.id_regdst = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
        bus.exmem_regwrite = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
        bus.memwb_regwrite = 0; bus.memwb_rd = '0; bus.memwb_result = '0;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                            input logic alusrc, input logic regdst, input logic rw,
                            input logic mr, input logic mw, input logic mtr);
        bus.id_valid = v; bus.id_pc = pc; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm32 = imm;
        bus.id_aluctrl = ALU_ADDU; bus.id_shamt = 5'd0; bus.id_alusrc = alusrc;
        bus.id_regdst = regdst; bus.id_regwrite = rw; bus.id_memread = mr;
        bus.id_memwrite = mw; bus.id_memtoreg = mtr;
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] raw);
        if (idx == 5'd0) return raw;
        if (bus.exmem_regwrite && bus.exmem_rd == idx) return bus.exmem_result;
        if (bus.memwb_regwrite && bus.memwb_rd == idx) return bus.memwb_result;
        return raw;
    endfunction

    function automatic bit ref_load_use();
        return m.valid && m.mr && (m.wreg != 5'd0) && bus.id_valid &&
               (m.wreg == bus.id_rs || m.wreg == bus.id_rt);
    endfunction

    task automatic model_clock();
        bit lu;
        lu = ref_load_use();
        if (rst) m = '{default: 0};
        else if (bus.stall) m = m;
        else if (bus.flush || lu) m = '{default: 0};
        else begin
            m.valid = bus.id_valid; m.pc = bus.id_pc; m.rs = bus.id_rs; m.rt = bus.id_rt;
            m.rsd = bus.id_rs_data; m.rtd = bus.id_rt_data; m.imm = bus.id_imm32;
            m.wreg = bus.id_regdst ? bus.id_rd : bus.id_rt;
            m.aluctrl = bus.id_aluctrl; m.shamt = bus.id_shamt; m.alusrc = bus.id_alusrc;
            m.rw = bus.id_valid && bus.id_regwrite; m.mr = bus.id_valid && bus.id_memread;
            m.mw = bus.id_valid && bus.id_memwrite; m.mtr = bus.id_valid && bus.id_memtoreg;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        drive_id(1, 32'hCAFE0000, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 0, 1, 1, 1, 0, 1);
        rst = 1;
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.ex_valid); end
        total++; if (bus.ex_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.ex_pc); end
        total++; if (bus.ex_data1 !== 32'h0 || bus.ex_data2 !== 32'h0 || bus.ex_store_data !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.ex_data1, bus.ex_data2, bus.ex_store_data); end
        total++; if ({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg); end
        total++; if (bus.ex_wreg !== 5'd0 || bus.ex_aluctrl !== 5'd0 || bus.ex_shamt !== 5'd0) begin
            bad++; $display("FAIL reset_fields got wreg=%0d alu=%0d shamt=%0d exp=0", bus.ex_wreg, bus.ex_aluctrl, bus.ex_shamt); end
        total++; if (bus.load_use !== 1'b0) begin bad++; $display("FAIL reset_load_use got=%b exp=0", bus.load_use); end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_capture();
        drive_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 0, 1, 1, 0, 0, 0);
        tick();
        idle_inputs();
        #1;
        total++; if (bus.ex_data1 !== 32'd5) begin bad++; $display("FAIL cap_data1 got=%h exp=5", bus.ex_data1); end
        total++; if (bus.ex_data2 !== 32'd7) begin bad++; $display("FAIL cap_data2 got=%h exp=7", bus.ex_data2); end
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_regwrite !== 1'b1) begin
            bad++; $display("FAIL cap_valid got valid=%b rw=%b exp=1/1", bus.ex_valid, bus.ex_regwrite); end
        total++; if (bus.ex_pc !== 32'h100 || bus.ex_wreg !== 5'd3 || bus.ex_aluctrl !== ALU_ADDU) begin
            bad++; $display("FAIL cap_fields got pc=%h wreg=%0d alu=%0d exp pc=100 wreg=3 alu=%0d", bus.ex_pc, bus.ex_wreg, bus.ex_aluctrl, ALU_ADDU); end
    endtask

    task automatic test_forward();
        drive_id(1, 32'h104, 5'd8, 5'd0, 5'd9, 32'h11, 32'h44, 32'h0, 0, 1, 1, 0, 0, 0);
        tick();
        idle_inputs();
        bus.exmem_regwrite = 1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'hAA;
        bus.memwb_regwrite = 1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'hBB;
        #1;
        total++; if (bus.ex_data1 !== 32'hAA) begin bad++; $display("FAIL fwd_exmem got=%h exp=aa", bus.ex_data1); end
        bus.exmem_regwrite = 0;
        #1;
        total++; if (bus.ex_data1 !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h exp=bb", bus.ex_data1); end
        bus.memwb_regwrite = 0;
        #1;
        total++; if (bus.ex_data1 !== 32'h11) begin bad++; $display("FAIL fwd_none got=%h exp=11", bus.ex_data1); end
        drive_id(1, 32'h108, 5'd0, 5'd0, 5'd9, 32'h33, 32'h44, 32'h0, 0, 1, 1, 0, 0, 0);
        tick();
        idle_inputs();
        bus.exmem_regwrite = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hAA;
        bus.memwb_regwrite = 1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hBB;
        #1;
        total++; if (bus.ex_data1 !== 32'h33) begin bad++; $display("FAIL fwd_r0_rs got=%h exp=33", bus.ex_data1); end
        total++; if (bus.ex_data2 !== 32'h44) begin bad++; $display("FAIL fwd_r0_rt got=%h exp=44", bus.ex_data2); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        drive_id(1, 32'h200, 5'd1, 5'd9, 5'd0, 32'h1000, 32'hDEAD, 32'h4, 1, 0, 1, 1, 0, 1);
        tick();
        drive_id(1, 32'h204, 5'd9, 5'd2, 5'd10, 32'hBAD, 32'h3, 32'h0, 0, 1, 1, 0, 0, 0);
        #1;
        total++; if (bus.load_use !== 1'b1) begin bad++; $display("FAIL lu_detect got=%b exp=1", bus.load_use); end
        total++; if (bus.ex_wreg !== 5'd9 || bus.ex_memread !== 1'b1) begin
            bad++; $display("FAIL lu_ex_lw got wreg=%0d mr=%b exp=9/1", bus.ex_wreg, bus.ex_memread); end
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0) begin
            bad++; $display("FAIL lu_bubble got valid=%b rw=%b exp=0/0", bus.ex_valid, bus.ex_regwrite); end
        total++; if (bus.load_use !== 1'b0) begin bad++; $display("FAIL lu_clear got=%b exp=0", bus.load_use); end
        tick();
        bus.memwb_regwrite = 1; bus.memwb_rd = 5'd9; bus.memwb_result = 32'h1234;
        #1;
        total++; if (bus.ex_data1 !== 32'h1234) begin bad++; $display("FAIL lu_fwd got=%h exp=1234", bus.ex_data1); end
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_wreg !== 5'd10 || bus.ex_data2 !== 32'h3) begin
            bad++; $display("FAIL lu_add got valid=%b wreg=%0d d2=%h exp=1/10/3", bus.ex_valid, bus.ex_wreg, bus.ex_data2); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        drive_id(1, 32'h300, 5'd6, 5'd7, 5'd20, 32'h66, 32'h77, 32'h0, 0, 1, 1, 0, 0, 0);
        bus.stall = 1; bus.flush = 1;
        tick();
        total++; if (bus.ex_pc !== 32'h204 || bus.ex_wreg !== 5'd10 || bus.ex_valid !== 1'b1) begin
            bad++; $display("FAIL stall_hold got pc=%h wreg=%0d valid=%b exp 204/10/1", bus.ex_pc, bus.ex_wreg, bus.ex_valid); end
        total++; if (bus.ex_data1 !== 32'hBAD || bus.ex_regwrite !== 1'b1) begin
            bad++; $display("FAIL stall_data got d1=%h rw=%b exp bad/1", bus.ex_data1, bus.ex_regwrite); end
        bus.stall = 0;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_wreg !== 5'd0) begin
            bad++; $display("FAIL flush_bubble got valid=%b rw=%b pc=%h wreg=%0d exp 0", bus.ex_valid, bus.ex_regwrite, bus.ex_pc, bus.ex_wreg); end
        idle_inputs();
    endtask

    task automatic test_immediate();
        drive_id(1, 32'h400, 5'd0, 5'd4, 5'd0, 32'h9, 32'h55, 32'hFFFFFFFC, 1, 0, 1, 0, 1, 0);
        tick();
        idle_inputs();
        bus.exmem_regwrite = 1; bus.exmem_rd = 5'd4; bus.exmem_result = 32'h77;
        #1;
        total++; if (bus.ex_data2 !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_data2 got=%h exp=fffffffc", bus.ex_data2); end
        total++; if (bus.ex_store_data !== 32'h77) begin bad++; $display("FAIL imm_store got=%h exp=77", bus.ex_store_data); end
        total++; if (bus.ex_data1 !== 32'h9) begin bad++; $display("FAIL imm_data1 got=%h exp=9", bus.ex_data1); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, es;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        m = '{default: 0};
        #1;
        rst = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            bus.stall = ($urandom_range(0, 99) < 12);
            bus.flush = ($urandom_range(0, 99) < 10);
            bus.id_valid = ($urandom_range(0, 99) < 80);
            bus.id_pc = $urandom; bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
            bus.id_imm32 = $urandom;
            bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 3));
            bus.id_shamt = 5'($urandom); bus.id_aluctrl = 5'($urandom);
            bus.id_alusrc = 1'($urandom); bus.id_regdst = 1'($urandom);
            bus.id_regwrite = 1'($urandom); bus.id_memread = ($urandom_range(0, 99) < 40);
            bus.id_memwrite = 1'($urandom); bus.id_memtoreg = 1'($urandom);
            bus.exmem_regwrite = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 3));
            bus.exmem_result = $urandom;
            bus.memwb_regwrite = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 3));
            bus.memwb_result = $urandom;
            #1;
            e1 = ref_operand(m.rs, m.rsd);
            es = ref_operand(m.rt, m.rtd);
            e2 = m.alusrc ? m.imm : es;
            total++; if (bus.load_use !== ref_load_use()) begin bad++; $display("FAIL rnd_load_use i=%0d got=%b exp=%b", i, bus.load_use, ref_load_use()); end
            total++; if (bus.ex_valid !== m.valid || bus.ex_pc !== m.pc) begin
                bad++; $display("FAIL rnd_valid_pc i=%0d got=%b/%h exp=%b/%h", i, bus.ex_valid, bus.ex_pc, m.valid, m.pc); end
            total++; if (bus.ex_data1 !== e1) begin bad++; $display("FAIL rnd_data1 i=%0d got=%h exp=%h", i, bus.ex_data1, e1); end
            total++; if (bus.ex_data2 !== e2) begin bad++; $display("FAIL rnd_data2 i=%0d got=%h exp=%h", i, bus.ex_data2, e2); end
            total++; if (bus.ex_store_data !== es) begin bad++; $display("FAIL rnd_store i=%0d got=%h exp=%h", i, bus.ex_store_data, es); end
            total++; if (bus.ex_aluctrl !== m.aluctrl || bus.ex_shamt !== m.shamt || bus.ex_wreg !== m.wreg) begin
                bad++; $display("FAIL rnd_fields i=%0d got alu=%0d sh=%0d wreg=%0d exp alu=%0d sh=%0d wreg=%0d",
                                i, bus.ex_aluctrl, bus.ex_shamt, bus.ex_wreg, m.aluctrl, m.shamt, m.wreg); end
            total++; if ({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg} !== {m.rw, m.mr, m.mw, m.mtr}) begin
                bad++; $display("FAIL rnd_ctrl i=%0d got=%b%b%b%b exp=%b%b%b%b", i, bus.ex_regwrite, bus.ex_memread,
                                bus.ex_memwrite, bus.ex_memtoreg, m.rw, m.mr, m.mw, m.mtr); end
            @(posedge clk);
            model_clock();
            #1;
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        #1;
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_immediate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
